// File: rtl/ext_bus_pkg.sv
// Shared decode constants and FSM state type for the external bus.
// The SoC-side initiator imports this too, so both ends decode command words identically.
package ext_bus_pkg;

  localparam int DATA_W       = 32;
  localparam int WR_BIT       = 31;
  localparam int LEN_LSB      = 24;
  localparam int CMD_LEN_W    = 4;
  localparam int BUS_TURN_CYC = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_TURN = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_RD_END  = 3'd4
  } ext_bus_state_t;

endpackage

// File: rtl/ext_bus_responder_if.sv
// Shared external bus signals as seen between the SoC (master) and the responder (slave).
// Handshake: the SoC strobes IN_busValid for each command or write beat and it is always taken;
// OUT_busReady marks an accepted write beat, or a valid read word while OUT_busOE drives the bus.
interface ext_bus_responder_if;
  logic [31:0] IN_bus;
  logic        IN_busValid;
  logic [31:0] OUT_bus;
  logic        OUT_busOE;
  logic        OUT_busReady;

  modport slave (
    input  IN_bus, IN_busValid,
    output OUT_bus, OUT_busOE, OUT_busReady
  );

  modport master (
    output IN_bus, IN_busValid,
    input  OUT_bus, OUT_busOE, OUT_busReady
  );
endinterface

// File: rtl/ext_bus_responder.sv
// Target endpoint of the external bus: decodes commands, bursts writes into a word SRAM,
// and returns pipelined burst reads framed by one-cycle bus turnarounds.
module ext_bus_responder
  import ext_bus_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = CMD_LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  ext_bus_responder_if.slave  bus,
  output logic                OUT_mem_ce,
  output logic                OUT_mem_we,
  output logic [ADDR_W-1:0]   OUT_mem_addr,
  output logic [DATA_W-1:0]   OUT_mem_data,
  input  logic [DATA_W-1:0]   IN_mem_data,
  output logic                OUT_err,
  output ext_bus_state_t      dbg_state_o
);

  ext_bus_state_t    state_q, state_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] beat_addr;
  logic [ADDR_W-1:0] next_addr;
  logic              last_beat;

  // Address arithmetic deliberately wraps modulo 2^ADDR_W.
  assign beat_addr = start_q + ADDR_W'(cnt_q);
  assign next_addr = beat_addr + ADDR_W'(1);
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d          = state_q;
    start_d          = start_q;
    len_d            = len_q;
    cnt_d            = cnt_q;
    err_d            = err_q;
    bus.OUT_bus      = '0;
    bus.OUT_busOE    = 1'b0;
    bus.OUT_busReady = 1'b0;
    OUT_mem_ce       = 1'b0;
    OUT_mem_we       = 1'b0;
    OUT_mem_addr     = '0;
    OUT_mem_data     = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.IN_busValid) begin
          start_d = bus.IN_bus[ADDR_W-1:0];
          len_d   = bus.IN_bus[LEN_LSB +: LEN_W];
          cnt_d   = '0;
          state_d = bus.IN_bus[WR_BIT] ? ST_WRITE : ST_RD_TURN;
        end
      end
      ST_WRITE: begin
        bus.OUT_busReady = 1'b1;
        if (bus.IN_busValid) begin
          OUT_mem_ce   = 1'b1;
          OUT_mem_we   = 1'b1;
          OUT_mem_addr = beat_addr;
          OUT_mem_data = bus.IN_bus;
          if (last_beat) state_d = ST_IDLE;
          else           cnt_d   = cnt_q + LEN_W'(1);
        end
      end
      ST_RD_TURN: begin
        // Bus is released this cycle while the first word is fetched.
        OUT_mem_ce   = 1'b1;
        OUT_mem_addr = beat_addr;
        state_d      = ST_RD_DATA;
        if (bus.IN_busValid) err_d = 1'b1;
      end
      ST_RD_DATA: begin
        bus.OUT_busOE    = 1'b1;
        bus.OUT_busReady = 1'b1;
        bus.OUT_bus      = IN_mem_data;
        if (last_beat) begin
          state_d = ST_RD_END;
        end else begin
          OUT_mem_ce   = 1'b1;
          OUT_mem_addr = next_addr;
          cnt_d        = cnt_q + LEN_W'(1);
        end
        if (bus.IN_busValid) err_d = 1'b1;
      end
      ST_RD_END: begin
        state_d = ST_IDLE;
        if (bus.IN_busValid) err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign OUT_err     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ext_bus_responder.sv
// Bench for ext_bus_responder: SRAM environment model, write scoreboard and a
// word-level reference memory that predicts every returned read word.
module tb_ext_bus_responder;
  import ext_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ext_bus_responder_if bus_if();
  logic           mem_ce, mem_we, err;
  logic [23:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic [31:0]    mem_rdata = 32'h0;
  ext_bus_state_t dbg_state;

  ext_bus_responder #(.ADDR_W(24), .LEN_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .OUT_mem_ce  (mem_ce),
    .OUT_mem_we  (mem_we),
    .OUT_mem_addr(mem_addr),
    .OUT_mem_data(mem_wdata),
    .IN_mem_data (mem_rdata),
    .OUT_err     (err),
    .dbg_state_o (dbg_state)
  );

  // SRAM environment: one-cycle read latency.
  logic [31:0] sram [int];
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) sram[int'(mem_addr)] = mem_wdata;
      else        mem_rdata <= sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : 32'h0;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [int];
  logic [55:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  bit exp_err  = 1'b0;

  function automatic logic [31:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  always @(negedge clk) begin
    #2;
    if (!rst && mem_ce && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sram_write: got unexpected write addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        logic [55:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          failures++;
          $display("FAIL sram_write: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, e[55:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [31:0] d);
    @(negedge clk);
    bus_if.IN_busValid = v;
    bus_if.IN_bus      = d;
    #1;
  endtask

  task automatic preload(input logic [23:0] a, input logic [31:0] d);
    sram[int'(a)]    = d;
    ref_mem[int'(a)] = d;
  endtask

  task automatic write_burst(input logic [23:0] start, input int len_m1, input int gap_pct, input bit idle_after);
    logic [31:0] d;
    logic [23:0] a;
    int i, gaps;
    step(1'b1, {1'b1, 3'($urandom), 4'(len_m1), start});
    checks++;
    if (bus_if.OUT_busReady !== 1'b0) begin
      failures++; $display("FAIL wr_cmd_ready: got %b, required 0", bus_if.OUT_busReady);
    end
    i = 0; gaps = 0;
    while (i <= len_m1) begin
      if (gaps < 2 * len_m1 + 4 && int'($urandom_range(99)) < gap_pct) begin
        gaps++;
        step(1'b0, $urandom);
        checks++;
        if (bus_if.OUT_busReady !== 1'b1 || mem_ce !== 1'b0) begin
          failures++; $display("FAIL wr_gap: got ready=%b ce=%b, required ready=1 ce=0", bus_if.OUT_busReady, mem_ce);
        end
      end else begin
        d = $urandom;
        a = start + 24'(i);
        exp_q.push_back({a, d});
        ref_mem[int'(a)] = d;
        step(1'b1, d);
        checks++;
        if (bus_if.OUT_busReady !== 1'b1 || bus_if.OUT_busOE !== 1'b0) begin
          failures++; $display("FAIL wr_beat_ready: got ready=%b oe=%b, required ready=1 oe=0", bus_if.OUT_busReady, bus_if.OUT_busOE);
        end
        i++;
      end
    end
    if (idle_after) begin
      step(1'b0, 32'h0);
      checks++;
      if (dbg_state !== ST_IDLE || bus_if.OUT_busReady !== 1'b0) begin
        failures++; $display("FAIL wr_done_idle: got state=%0d ready=%b, required IDLE ready=0", dbg_state, bus_if.OUT_busReady);
      end
    end
  endtask

  // inj_beat: beat index at which IN_busValid is illegally raised (-1 none).
  // rst_beat: beat index during which rst is asserted (-1 none).
  task automatic read_burst(input logic [23:0] start, input int len_m1, input int inj_beat, input int rst_beat);
    logic [31:0] e;
    step(1'b1, {1'b0, 3'($urandom), 4'(len_m1), start});
    checks++;
    if (bus_if.OUT_busReady !== 1'b0 || bus_if.OUT_busOE !== 1'b0) begin
      failures++; $display("FAIL rd_cmd: got ready=%b oe=%b, required 0 0", bus_if.OUT_busReady, bus_if.OUT_busOE);
    end
    step(1'b0, $urandom);
    checks++;
    if (bus_if.OUT_busOE !== 1'b0 || bus_if.OUT_bus !== 32'h0 || bus_if.OUT_busReady !== 1'b0 ||
        mem_ce !== 1'b1 || mem_we !== 1'b0 || mem_addr !== start) begin
      failures++;
      $display("FAIL rd_turn: got oe=%b bus=%h rdy=%b ce=%b we=%b addr=%h, required oe=0 bus=0 rdy=0 ce=1 we=0 addr=%h",
               bus_if.OUT_busOE, bus_if.OUT_bus, bus_if.OUT_busReady, mem_ce, mem_we, mem_addr, start);
    end
    for (int b = 0; b <= len_m1; b++) begin
      step(b == inj_beat, $urandom);
      if (b == inj_beat) exp_err = 1'b1;
      if (b == rst_beat) rst = 1'b1;
      e = ref_rd(start + 24'(b));
      checks++;
      if (bus_if.OUT_busOE !== 1'b1 || bus_if.OUT_busReady !== 1'b1 || bus_if.OUT_bus !== e) begin
        failures++;
        $display("FAIL rd_beat b=%0d: got bus=%h oe=%b rdy=%b, required bus=%h oe=1 rdy=1",
                 b, bus_if.OUT_bus, bus_if.OUT_busOE, bus_if.OUT_busReady, e);
      end
      if (inj_beat >= 0 && b > inj_beat) begin
        checks++;
        if (err !== 1'b1) begin
          failures++; $display("FAIL err_sticky b=%0d: got %b, required 1", b, err);
        end
      end
      if (b == rst_beat) begin
        step(1'b0, 32'h0);
        rst = 1'b0;
        exp_err = 1'b0;
        checks++;
        if (bus_if.OUT_busOE !== 1'b0 || bus_if.OUT_busReady !== 1'b0 || bus_if.OUT_bus !== 32'h0 ||
            mem_ce !== 1'b0 || err !== 1'b0) begin
          failures++;
          $display("FAIL rst_mid: got oe=%b rdy=%b bus=%h ce=%b err=%b, required all 0",
                   bus_if.OUT_busOE, bus_if.OUT_busReady, bus_if.OUT_bus, mem_ce, err);
        end
        return;
      end
    end
    step(1'b0, 32'h0);
    checks++;
    if (bus_if.OUT_busOE !== 1'b0 || bus_if.OUT_busReady !== 1'b0 || bus_if.OUT_bus !== 32'h0 || err !== exp_err) begin
      failures++;
      $display("FAIL rd_end: got oe=%b rdy=%b bus=%h err=%b, required oe=0 rdy=0 bus=0 err=%b",
               bus_if.OUT_busOE, bus_if.OUT_busReady, bus_if.OUT_bus, err, exp_err);
    end
    step(1'b0, 32'h0);
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL rd_idle: got state=%0d, required IDLE", dbg_state);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    checks++;
    if (bus_if.OUT_busOE !== 1'b0 || bus_if.OUT_bus !== 32'h0 || bus_if.OUT_busReady !== 1'b0 ||
        mem_ce !== 1'b0 || mem_we !== 1'b0 || err !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset: got oe=%b bus=%h rdy=%b ce=%b we=%b err=%b state=%0d, required all 0 / IDLE",
               bus_if.OUT_busOE, bus_if.OUT_bus, bus_if.OUT_busReady, mem_ce, mem_we, err, dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    step(1'b1, 32'h8000_0010);
    checks++;
    if (bus_if.OUT_busReady !== 1'b0) begin
      failures++; $display("FAIL single_cmd_ready: got %b, required 0", bus_if.OUT_busReady);
    end
    exp_q.push_back({24'h000010, 32'hDEAD_BEEF});
    ref_mem[32'h10] = 32'hDEAD_BEEF;
    step(1'b1, 32'hDEAD_BEEF);
    checks++;
    if (bus_if.OUT_busReady !== 1'b1 || mem_ce !== 1'b1 || mem_we !== 1'b1 ||
        mem_addr !== 24'h000010 || mem_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL single_beat: got rdy=%b ce=%b we=%b addr=%h data=%h, required 1 1 1 000010 deadbeef",
               bus_if.OUT_busReady, mem_ce, mem_we, mem_addr, mem_wdata);
    end
    step(1'b0, 32'h0);
    checks++;
    if (dbg_state !== ST_IDLE || bus_if.OUT_busReady !== 1'b0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL single_idle: got state=%0d rdy=%b wdata=%h, required IDLE 0 0", dbg_state, bus_if.OUT_busReady, mem_wdata);
    end
  endtask

  task automatic test_burst_write_gaps();
    bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] d;
    int n;
    step(1'b1, 32'h8300_0100);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      d = $urandom;
      if (pat[k]) begin
        exp_q.push_back({24'h000100 + 24'(n), d});
        ref_mem[32'h100 + n] = d;
        n++;
      end
      step(pat[k], d);
      if (!pat[k]) begin
        checks++;
        if (mem_ce !== 1'b0) begin
          failures++; $display("FAIL gap_no_write k=%0d: got ce=%b, required 0", k, mem_ce);
        end
      end
    end
    step(1'b0, 32'h0);
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL gap_burst_idle: got state=%0d, required IDLE", dbg_state);
    end
    for (int r = 0; r < 3; r++)
      write_burst(24'($urandom_range(32'h3FF, 32'h200)), int'($urandom_range(15)), 30, 1'b1);
  endtask

  task automatic test_burst_read();
    for (int k = 0; k < 4; k++) preload(24'h20 + 24'(k), 32'(k + 1));
    read_burst(24'h000020, 3, -1, -1);
    read_burst(24'h000100, 3, -1, -1);
  endtask

  task automatic test_addr_wrap();
    preload(24'hFFFFFF, $urandom);
    preload(24'h000000, $urandom);
    read_burst(24'hFFFFFF, 1, -1, -1);
    write_burst(24'hFFFFFD, 5, 20, 1'b1);
    read_burst(24'hFFFFFC, 7, -1, -1);
  endtask

  task automatic test_protocol_error();
    read_burst(24'h000100, 3, 1, -1);
    read_burst(24'h000020, 2, -1, -1);
  endtask

  task automatic test_reset_mid_burst();
    read_burst(24'h000020, 3, 0, 2);
    write_burst(24'h000300, 2, 0, 1'b1);
    read_burst(24'h000300, 2, -1, -1);
  endtask

  task automatic test_back_to_back();
    logic [23:0] a;
    int len;
    write_burst(24'h000400, 3, 0, 1'b0);
    read_burst(24'h000400, 3, -1, -1);
    for (int r = 0; r < 10; r++) begin
      a   = 24'($urandom);
      len = int'($urandom_range(15));
      if ($urandom_range(1) == 1) begin
        write_burst(a, len, 25, 1'b0);
        read_burst(a, len, -1, -1);
      end else begin
        read_burst(a, len, -1, -1);
      end
    end
  endtask

  initial begin
    bus_if.IN_bus      = 32'h0;
    bus_if.IN_busValid = 1'b0;
    test_reset();
    test_single_write();
    test_burst_write_gaps();
    test_burst_read();
    test_addr_wrap();
    test_protocol_error();
    test_reset_mid_burst();
    test_back_to_back();
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL wr_queue_drain: got %0d pending writes, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got time limit reached, required normal completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_bus_responder.md
Name: ext_bus_responder

Overview:
- Target-side endpoint of the SoC's 32-bit shared external bus (bus word, bus output-enable, bus valid, bus ready).
- Decodes command words from the SoC. Performs burst writes into a backing single-port word SRAM, and returns burst read data by driving the bus after a turnaround.
- Used in the FPGA companion and as a synthesizable bench model for full-chip simulation.

Parameters:
- ADDR_W, 24, word-address width carried in the command word (max 24).
- LEN_W, 4, burst length field width; burst = len_m1+1 words (1..16).

Ports:
- clk  in  1  core clock, same clock as the SoC bus
- rst  in  1  reset; synchronous, active-high
- IN_bus  in  32  bus word driven by the SoC
- IN_busValid  in  1  SoC beat strobe (command or write data)
- OUT_bus  out  32  read data driven toward the SoC
- OUT_busOE  out  1  responder drives the bus when 1
- OUT_busReady  out  1  write beat accepted / read beat valid
- OUT_mem_ce  out  1  SRAM access enable, active-high
- OUT_mem_we  out  1  SRAM write, active-high (qualified by ce)
- OUT_mem_addr  out  ADDR_W  SRAM word address
- OUT_mem_data  out  32  SRAM write data
- IN_mem_data  in  32  SRAM read data, valid 1 cycle after a ce&!we cycle
- OUT_err  out  1  sticky protocol-error flag

Behaviour:
- Reset values (and next cycle after rst=1 at any time, including mid-burst):
  - OUT_busOE=0, OUT_bus=0, OUT_busReady=0, OUT_mem_ce=0, OUT_mem_we=0, OUT_err=0.
  - State=IDLE; in-flight bursts are abandoned.
- Command word fields: [31]=write, [30:28] reserved (ignored), [27:24]=len_m1, [ADDR_W-1:0]=start word address.
- States: IDLE, WRITE, RD_TURN, RD_DATA, RD_END.
- IDLE:
  - On IN_busValid=1, latch the command and set beat counter cnt=0.
  - Transition to WRITE if write=1, else RD_TURN.
  - OUT_busReady=0 in the command cycle.
- WRITE:
  - OUT_busReady=1 (combinational from state). No backpressure is ever applied.
  - Each cycle with IN_busValid=1 is a data beat: OUT_mem_ce=1, OUT_mem_we=1, addr=start+cnt, data=IN_bus, cnt++.
  - Cycles with IN_busValid=0 are idle gaps: no SRAM access, cnt held.
  - After the beat where cnt==len_m1 is written, go to IDLE. The next command is accepted in the following cycle.
- RD_TURN: exactly 1 cycle. OUT_busOE=0. Issue SRAM read of start+0 (ce=1, we=0). Go to RD_DATA.
- RD_DATA:
  - OUT_busOE=1, OUT_busReady=1, OUT_bus=IN_mem_data, one word per cycle with no gaps.
  - Reads are pipelined: each RD_DATA cycle also reads start+cnt+1 while beats remain.
  - First data word appears 2 cycles after the command cycle.
  - After beat len_m1, go to RD_END.
- RD_END: exactly 1 cycle. OUT_busOE=0, OUT_busReady=0, OUT_bus=0. Go to IDLE.
- Address arithmetic: start+cnt wraps modulo 2^ADDR_W (e.g. start=FFFFFF, len 2 -> FFFFFF, 000000).
- Protocol errors (set OUT_err=1 sticky until rst; the beat is ignored, no SRAM access, state unaffected):
  - IN_busValid=1 in RD_TURN, RD_DATA or RD_END.
- OUT_busOE is never 1 in the cycle before or after a SoC-driven cycle; the RD_TURN/RD_END turnaround guarantees this.
- OUT_bus is forced to 0 whenever OUT_busOE=0.
- OUT_mem_data=IN_bus only when a write beat occurs, otherwise 0.

Decomposition:
- Shared package (ext_bus_pkg):
  - Command-word field positions (WR_BIT=31, LEN_LSB=24, LEN_W).
  - State enum ext_bus_state_t.
  - Turnaround length constant BUS_TURN_CYC=1.
- The same package is imported by the SoC-side bus initiator so both ends decode identically.
- No sub-module; a single FSM with a counter and an address adder.

Test Plan:
- Single write: command 0x8000_0010 then data 0xDEADBEEF with valid -> SRAM write addr 0x10 data DEADBEEF; OUT_busReady=1 that cycle; back to IDLE next cycle.
- Burst write with gaps: command 0x8300_0100, 4 data beats interleaved with 2 valid=0 cycles -> exactly 4 writes to 0x100..0x103 in order; no write in the gap cycles.
- Burst read: preload 0x20..0x23 = 1,2,3,4; command 0x0300_0020 at cycle T -> OE=0 at T+1; OE=1, Ready=1 with data 1,2,3,4 at T+2..T+5; OE=0 at T+6; IDLE at T+7.
- Address wrap: read command 0x01FF_FFFF -> SRAM reads FFFFFF then 000000; returned words match.
- Protocol error: IN_busValid=1 during RD_DATA -> OUT_err=1 and stays 1; read data sequence unchanged.
- Reset mid-burst: rst=1 during the 3rd RD_DATA beat -> next cycle OE=0, Ready=0, ce=0, err=0; a new write command after rst completes normally.
